// File: rtl/prescaled_counter.sv
// -----------------------------------------------------------------------------
// prescaled_counter
//
// Event counter driven through a runtime-programmable prescaler. Every
// (prescale_i + 1) enabled cycles the counter takes one step, either up or
// down. An up-count stops at limit_i and a down-count stops at zero. At that
// boundary the counter either wraps (SATURATE=0) or holds (SATURATE=1). Two
// registered pulses are provided so other blocks can chain off this one:
// tick_o marks each prescaler rollover, and wrap_o marks each step that
// reached the boundary.
//
// Parameters
//   COUNT_WIDTH     width of count_o, load_value_i and limit_i
//   PRESCALE_WIDTH  width of prescale_i and the internal prescale counter
//   SATURATE        0 = wrap at the boundary, 1 = hold at the boundary
//
// Ports
//   clock_i       in   clock, all state changes on the rising edge
//   reset_i       in   synchronous active-high reset
//   enable_i      in   advance the prescaler this cycle
//   up_i          in   1 = count up, 0 = count down (sampled on each step)
//   load_i        in   synchronous load of the count, clears the prescaler
//   load_value_i  in   value loaded when load_i = 1
//   prescale_i    in   divide ratio minus one
//   limit_i       in   up-count terminal value / down-wrap reload value
//   count_o       out  registered count
//   tick_o        out  registered pulse on every prescaler rollover
//   wrap_o        out  registered pulse when a step hits the boundary
// -----------------------------------------------------------------------------
module prescaled_counter #(
    parameter int COUNT_WIDTH    = 8,
    parameter int PRESCALE_WIDTH = 3,
    parameter bit SATURATE       = 1'b0
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic                      up_i,
    input  logic                      load_i,
    input  logic [COUNT_WIDTH-1:0]    load_value_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic [COUNT_WIDTH-1:0]    limit_i,
    output logic [COUNT_WIDTH-1:0]    count_o,
    output logic                      tick_o,
    output logic                      wrap_o
);

    localparam logic [COUNT_WIDTH-1:0]    COUNT_ONE = COUNT_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PCNT_ONE  = PRESCALE_WIDTH'(1);

    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic [PRESCALE_WIDTH-1:0] pcnt_q,  pcnt_d;
    logic                      tick_q,  tick_d;
    logic                      wrap_q,  wrap_d;

    // Rollover and boundary decode.
    logic rollover;
    logic at_upper;
    logic at_lower;

    // The >= compare (rather than ==) keeps the prescaler from running past
    // the new period when prescale_i is lowered below the current progress.
    assign rollover = (pcnt_q >= prescale_i);
    // A count that is already above the limit also counts as a boundary on
    // an up step, so a load above limit_i wraps or holds on the next step.
    assign at_upper = (count_q >= limit_i);
    assign at_lower = (count_q == '0);

    // Next-state logic. Priority is load, then enable. Reset is applied in
    // the register process.
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        pcnt_d  = pcnt_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (load_i) begin
            count_d = load_value_i;
            pcnt_d  = '0;
        end else if (enable_i) begin
            if (rollover) begin
                pcnt_d = '0;
                tick_d = 1'b1;
                if (up_i) begin
                    if (at_upper) begin
                        wrap_d  = 1'b1;
                        count_d = SATURATE ? count_q : '0;
                    end else begin
                        count_d = count_q + COUNT_ONE;
                    end
                end else begin
                    if (at_lower) begin
                        wrap_d  = 1'b1;
                        count_d = SATURATE ? '0 : limit_i;
                    end else begin
                        count_d = count_q - COUNT_ONE;
                    end
                end
            end else begin
                pcnt_d = pcnt_q + PCNT_ONE;
            end
        end
    end

    // State register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge, whatever the
    // statement order.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
            pcnt_q  <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            pcnt_q  <= pcnt_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign tick_o  = tick_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// -----------------------------------------------------------------------------
// tb_prescaled_counter
//
// Directed bench for prescaled_counter. Two instances share every input: one
// built in wrap mode (SATURATE=0) and one in saturate mode (SATURATE=1). Each
// scenario task drives its stimulus and compares the outputs against values
// worked out by hand.
// -----------------------------------------------------------------------------
module tb_prescaled_counter;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       enable_i = 1'b0;
    logic       up_i = 1'b1;
    logic       load_i = 1'b0;
    logic [7:0] load_value_i = '0;
    logic [2:0] prescale_i = 3'd7;
    logic [7:0] limit_i = 8'd255;

    logic [7:0] count_w, count_s;
    logic       tick_w, tick_s;
    logic       wrap_w, wrap_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock_i = ~clock_i;

    prescaled_counter #(.COUNT_WIDTH(8), .PRESCALE_WIDTH(3), .SATURATE(1'b0)) dut_wrap (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .up_i(up_i),
        .load_i(load_i), .load_value_i(load_value_i), .prescale_i(prescale_i),
        .limit_i(limit_i), .count_o(count_w), .tick_o(tick_w), .wrap_o(wrap_w)
    );

    prescaled_counter #(.COUNT_WIDTH(8), .PRESCALE_WIDTH(3), .SATURATE(1'b1)) dut_sat (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .up_i(up_i),
        .load_i(load_i), .load_value_i(load_value_i), .prescale_i(prescale_i),
        .limit_i(limit_i), .count_o(count_s), .tick_o(tick_s), .wrap_o(wrap_s)
    );

    // Advance one rising edge and settle 1 time unit past it, clear of the edge.
    task automatic cyc();
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1; load_i = 1'b0; enable_i = 1'b0;
        cyc();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        up_i = 1'b1; prescale_i = 3'd7; limit_i = 8'd255;
        do_reset();
        vectors++;
        if (count_w !== 8'd0) begin miscompares++; $display("FAIL reset_count_w: got %0d expected 0", count_w); end
        vectors++;
        if (count_s !== 8'd0) begin miscompares++; $display("FAIL reset_count_s: got %0d expected 0", count_s); end
        vectors++;
        if (tick_w !== 1'b0 || tick_s !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b/%b expected 0/0", tick_w, tick_s); end
        vectors++;
        if (wrap_w !== 1'b0 || wrap_s !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %b/%b expected 0/0", wrap_w, wrap_s); end
    endtask

    // Legacy divide-by-8: one tick every 8 enabled cycles, no boundary.
    task automatic test_legacy();
        int ticks = 0;
        bit wrap_seen = 1'b0;
        logic exp_tick;
        prescale_i = 3'd7; limit_i = 8'd255; up_i = 1'b1; enable_i = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            cyc();
            exp_tick = ((i % 8) == 0);
            vectors++;
            if (tick_w !== exp_tick) begin
                miscompares++;
                $display("FAIL legacy_tick cycle %0d: got %b expected %b", i, tick_w, exp_tick);
            end
            if (tick_w === 1'b1) ticks++;
            if (wrap_w !== 1'b0 || wrap_s !== 1'b0) wrap_seen = 1'b1;
        end
        enable_i = 1'b0;
        vectors++;
        if (count_w !== 8'd8) begin miscompares++; $display("FAIL legacy_count_w: got %0d expected 8", count_w); end
        vectors++;
        if (count_s !== 8'd8) begin miscompares++; $display("FAIL legacy_count_s: got %0d expected 8", count_s); end
        vectors++;
        if (ticks != 8) begin miscompares++; $display("FAIL legacy_ticks: got %0d expected 8", ticks); end
        vectors++;
        if (wrap_seen) begin miscompares++; $display("FAIL legacy_wrap: got 1 expected 0"); end
    endtask

    // Enable gaps hold progress; reset discards partial prescale progress.
    task automatic test_gaps_reset();
        do_reset();
        prescale_i = 3'd3; limit_i = 8'd255; up_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            enable_i = ((i % 2) == 0);
            cyc();
        end
        vectors++;
        if (count_w !== 8'd2) begin miscompares++; $display("FAIL gaps_count: got %0d expected 2", count_w); end
        // Two more enabled cycles bring pcnt to 2 without a step.
        enable_i = 1'b1;
        cyc(); cyc();
        vectors++;
        if (count_w !== 8'd2 || tick_w !== 1'b0) begin
            miscompares++; $display("FAIL gaps_partial: got count %0d tick %b expected 2 0", count_w, tick_w);
        end
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        vectors++;
        if (count_w !== 8'd0 || tick_w !== 1'b0) begin
            miscompares++; $display("FAIL gaps_reset: got count %0d tick %b expected 0 0", count_w, tick_w);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++;
            if (tick_w !== 1'b0 || count_w !== 8'd0) begin
                miscompares++; $display("FAIL gaps_fresh_%0d: got count %0d tick %b expected 0 0", i, count_w, tick_w);
            end
        end
        cyc();
        vectors++;
        if (tick_w !== 1'b1 || count_w !== 8'd1) begin
            miscompares++; $display("FAIL gaps_fourth: got count %0d tick %b expected 1 1", count_w, tick_w);
        end
        enable_i = 1'b0;
    endtask

    task automatic load_value(input logic [7:0] v);
        load_i = 1'b1; load_value_i = v; enable_i = 1'b0;
        cyc();
        load_i = 1'b0;
        vectors++;
        if (count_w !== v || count_s !== v || tick_w !== 1'b0 || wrap_w !== 1'b0) begin
            miscompares++;
            $display("FAIL load_%0d: got %0d/%0d tick %b wrap %b expected %0d/%0d 0 0",
                     v, count_w, count_s, tick_w, wrap_w, v, v);
        end
    endtask

    task automatic test_up_boundary();
        logic [7:0] exp_cw [3] = '{8'd10, 8'd0, 8'd1};
        logic       exp_ww [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] exp_cs [3] = '{8'd10, 8'd10, 8'd10};
        logic       exp_ws [3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        limit_i = 8'd10; prescale_i = 3'd0; up_i = 1'b1;
        load_value(8'd9);
        enable_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++;
            if (count_w !== exp_cw[i] || wrap_w !== exp_ww[i]) begin
                miscompares++; $display("FAIL up_wrap step %0d: got %0d/%b expected %0d/%b", i, count_w, wrap_w, exp_cw[i], exp_ww[i]);
            end
            vectors++;
            if (count_s !== exp_cs[i] || wrap_s !== exp_ws[i]) begin
                miscompares++; $display("FAIL up_sat step %0d: got %0d/%b expected %0d/%b", i, count_s, wrap_s, exp_cs[i], exp_ws[i]);
            end
        end
        enable_i = 1'b0;
    endtask

    task automatic test_down_boundary();
        logic [7:0] exp_cw [3] = '{8'd0, 8'd5, 8'd4};
        logic       exp_ww [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] exp_cs [3] = '{8'd0, 8'd0, 8'd0};
        logic       exp_ws [3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        limit_i = 8'd5; prescale_i = 3'd0; up_i = 1'b0;
        load_value(8'd1);
        enable_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++;
            if (count_w !== exp_cw[i] || wrap_w !== exp_ww[i]) begin
                miscompares++; $display("FAIL down_wrap step %0d: got %0d/%b expected %0d/%b", i, count_w, wrap_w, exp_cw[i], exp_ww[i]);
            end
            vectors++;
            if (count_s !== exp_cs[i] || wrap_s !== exp_ws[i]) begin
                miscompares++; $display("FAIL down_sat step %0d: got %0d/%b expected %0d/%b", i, count_s, wrap_s, exp_cs[i], exp_ws[i]);
            end
        end
        enable_i = 1'b0;
        up_i = 1'b1;
    endtask

    task automatic test_load_priority();
        do_reset();
        prescale_i = 3'd3; limit_i = 8'd255; up_i = 1'b1; enable_i = 1'b1;
        cyc(); cyc(); cyc();
        // pcnt is now 3, so this enabled cycle would roll; the load wins.
        load_i = 1'b1; load_value_i = 8'hA5;
        cyc();
        load_i = 1'b0;
        vectors++;
        if (count_w !== 8'hA5 || tick_w !== 1'b0 || wrap_w !== 1'b0) begin
            miscompares++; $display("FAIL load_over_enable: got %h tick %b wrap %b expected a5 0 0", count_w, tick_w, wrap_w);
        end
        // Load cleared pcnt: three quiet enabled cycles, then a step.
        cyc(); cyc(); cyc();
        vectors++;
        if (tick_w !== 1'b0 || count_w !== 8'hA5) begin
            miscompares++; $display("FAIL load_pcnt_cleared: got %h tick %b expected a5 0", count_w, tick_w);
        end
        cyc();
        vectors++;
        if (tick_w !== 1'b1 || count_w !== 8'hA6) begin
            miscompares++; $display("FAIL load_next_step: got %h tick %b expected a6 1", count_w, tick_w);
        end
        reset_i = 1'b1; load_i = 1'b1; load_value_i = 8'h3C;
        cyc();
        reset_i = 1'b0; load_i = 1'b0; enable_i = 1'b0;
        vectors++;
        if (count_w !== 8'd0 || count_s !== 8'd0) begin
            miscompares++; $display("FAIL reset_over_load: got %0d/%0d expected 0/0", count_w, count_s);
        end
    endtask

    task automatic test_shrink_above_limit();
        do_reset();
        prescale_i = 3'd7; limit_i = 8'd255; up_i = 1'b1; enable_i = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        vectors++;
        if (tick_w !== 1'b0 || count_w !== 8'd0) begin
            miscompares++; $display("FAIL shrink_before: got %0d tick %b expected 0 0", count_w, tick_w);
        end
        prescale_i = 3'd2;
        cyc();
        vectors++;
        if (tick_w !== 1'b1 || count_w !== 8'd1) begin
            miscompares++; $display("FAIL shrink_step: got %0d tick %b expected 1 1", count_w, tick_w);
        end
        limit_i = 8'd100; prescale_i = 3'd0;
        load_value(8'd200);
        enable_i = 1'b1;
        cyc();
        enable_i = 1'b0;
        vectors++;
        if (count_w !== 8'd0 || wrap_w !== 1'b1) begin
            miscompares++; $display("FAIL above_limit_wrap: got %0d wrap %b expected 0 1", count_w, wrap_w);
        end
        vectors++;
        if (count_s !== 8'd200 || wrap_s !== 1'b1) begin
            miscompares++; $display("FAIL above_limit_sat: got %0d wrap %b expected 200 1", count_s, wrap_s);
        end
    endtask

    // limit_i = 0 makes every up step a boundary.
    task automatic test_limit_zero();
        do_reset();
        limit_i = 8'd0; prescale_i = 3'd0; up_i = 1'b1;
        load_value(8'd3);
        enable_i = 1'b1;
        cyc();
        vectors++;
        if (count_w !== 8'd0 || wrap_w !== 1'b1) begin
            miscompares++; $display("FAIL limit0_wrap: got %0d wrap %b expected 0 1", count_w, wrap_w);
        end
        vectors++;
        if (count_s !== 8'd3 || wrap_s !== 1'b1) begin
            miscompares++; $display("FAIL limit0_sat: got %0d wrap %b expected 3 1", count_s, wrap_s);
        end
        cyc();
        enable_i = 1'b0;
        vectors++;
        if (count_w !== 8'd0 || wrap_w !== 1'b1 || tick_w !== 1'b1) begin
            miscompares++; $display("FAIL limit0_again: got %0d wrap %b tick %b expected 0 1 1", count_w, wrap_w, tick_w);
        end
        cyc();
        vectors++;
        if (tick_w !== 1'b0 || wrap_w !== 1'b0 || count_w !== 8'd0) begin
            miscompares++; $display("FAIL hold_clears_pulses: got %0d tick %b wrap %b expected 0 0 0", count_w, tick_w, wrap_w);
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_gaps_reset();
        test_up_boundary();
        test_down_boundary();
        test_load_priority();
        test_shrink_above_limit();
        test_limit_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
